// File: rtl/uart_tx_core.sv
// uart_tx_core: parametrised UART transmitter (FSM, baud divider, shift
// register, parity generator, registered line driver).
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   data_in     frame payload, latched on acceptance
//   data_valid  source presents a word
//   data_ready  core accepts a word this cycle (IDLE or last stop cycle)
//   par_en      insert parity bit (latched on acceptance)
//   par_odd     1 = odd parity, 0 = even (latched on acceptance)
//   two_stop    1 = two stop bits (latched on acceptance)
//   tx_out      serial line, idle high, registered
//   busy        frame in progress, registered
//   frame_done  one-cycle pulse in the last clk of the final stop bit
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  two_stop,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;      // data bit index, or stop bit index in STOP
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic baud_wrap;
  logic stop_last;
  logic last_stop;
  logic accept;

  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign stop_last  = two_stop_q ? (bit_q == BIT_W'(1)) : (bit_q == '0);
  assign last_stop  = (state_q == STOP) && baud_wrap && stop_last;
  assign data_ready = !reset && ((state_q == IDLE) || last_stop);
  assign frame_done = !reset && last_stop;
  assign accept     = data_valid && data_ready;
  assign tx_out     = tx_q;
  assign busy       = busy_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_wrap ? '0 : baud_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (accept) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (stop_last) begin
            state_d = accept ? START : IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // accept can only be true in IDLE or the last stop cycle, so loading the
    // frame here covers both the idle start and the gap-free follow-on frame.
    // The parity bit is precomputed from the payload at load time.
    if (accept) begin
      shift_d    = data_in;
      par_bit_d  = ^data_in ^ par_odd;
      par_en_d   = par_en;
      two_stop_d = two_stop;
    end

    // Line level is derived from the next state so tx_out is registered yet
    // the start bit appears right after the acceptance edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: two instances (8 bit / 4 clk and
// 5 bit / 2 clk), directed scenarios plus randomized frames, checked per
// cycle against a bit-list model of the UART frame.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] din;
  logic        dv_a, dv_b, pe, po, ts;
  logic        ready_a, tx_a, busy_a, fd_a;
  logic        ready_b, tx_b, busy_b, fd_b;
  logic        sel;
  logic        ready_s, tx_s, busy_s, fd_s;
  int          checks = 0;
  int          failures = 0;

  uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .reset(reset), .data_in(din[7:0]), .data_valid(dv_a),
    .data_ready(ready_a), .par_en(pe), .par_odd(po), .two_stop(ts),
    .tx_out(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  uart_tx_core #(.DATA_WIDTH(5), .CLKS_PER_BIT(2)) u_b (
    .clk(clk), .reset(reset), .data_in(din[4:0]), .data_valid(dv_b),
    .data_ready(ready_b), .par_en(pe), .par_odd(po), .two_stop(ts),
    .tx_out(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  assign ready_s = sel ? ready_b : ready_a;
  assign tx_s    = sel ? tx_b    : tx_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign fd_s    = sel ? fd_b    : fd_a;

  // Frame as a list of bit slots: start, w data bits LSB first, optional
  // parity, then stop bits (every slot past the payload is a 1).
  function automatic logic exp_bit(logic [15:0] d, int w, logic p_e, logic p_o, int k);
    int ones = 0;
    if (k == 0) return 1'b0;
    if (k <= w) return d[k-1];
    if (p_e && k == w + 1) begin
      for (int i = 0; i < w; i++) ones += int'(d[i]);
      return ((ones % 2) == 1) ^ p_o;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel) dv_b = v; else dv_a = v;
  endtask

  // Present a word at a negedge while the core is idle.
  task automatic present(input logic s, input logic [15:0] d, input logic p_e, p_o, t_s);
    @(negedge clk);
    sel = s; din = d; pe = p_e; po = p_o; ts = t_s;
    drive_valid(1'b1);
    chk("ready_idle", ready_s, 1'b1);
  endtask

  // Checks one frame whose acceptance edge is the next posedge. If
  // present_at > 0 the next word is offered from that cycle on and is taken
  // at the final stop edge.
  task automatic frame(input logic [15:0] d, input logic p_e, p_o, t_s,
                       input int present_at, input logic [15:0] nd,
                       input logic npe, npo, nts);
    int w;
    int cpb;
    int len;
    w   = sel ? 5 : 8;
    cpb = sel ? 2 : 4;
    len = (2 + w + int'(p_e) + int'(t_s)) * cpb;
    @(posedge clk);
    #1;
    dv_a = 1'b0; dv_b = 1'b0;
    din = 16'($urandom); pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == present_at) begin
        din = nd; pe = npe; po = npo; ts = nts;
        drive_valid(1'b1);
      end
      chk("tx_bit", tx_s, exp_bit(d, w, p_e, p_o, (c - 1) / cpb));
      chk("busy_frame", busy_s, 1'b1);
      chk("ready_frame", ready_s, c == len);
      chk("frame_done", fd_s, c == len);
    end
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_tx", tx_s, 1'b1);
    chk("idle_busy", busy_s, 1'b0);
    chk("idle_ready", ready_s, 1'b1);
    chk("idle_done", fd_s, 1'b0);
  endtask

  task automatic rand_frames(input logic s, input int n);
    logic [15:0] cd, nd;
    logic        cpe, cpo, cts, npe, npo, nts;
    logic        chain;
    logic [15:0] mask;
    mask = s ? 16'h001F : 16'h00FF;
    cd = 16'($urandom) & mask;
    cpe = 1'($urandom); cpo = 1'($urandom); cts = 1'($urandom);
    present(s, cd, cpe, cpo, cts);
    for (int i = 0; i < n; i++) begin
      chain = (i < n - 1) && ($urandom_range(0, 1) == 1);
      nd = 16'($urandom) & mask;
      npe = 1'($urandom); npo = 1'($urandom); nts = 1'($urandom);
      frame(cd, cpe, cpo, cts, chain ? int'($urandom_range(1, 14)) : 0, nd, npe, npo, nts);
      if (!chain) begin
        idle_chk();
        if (i < n - 1) present(s, nd, npe, npo, nts);
      end
      cd = nd; cpe = npe; cpo = npo; cts = nts;
    end
    idle_chk();
  endtask

  initial begin
    logic [15:0] rd;
    reset = 1'b1; dv_a = 1'b0; dv_b = 1'b0; din = '0;
    pe = 1'b0; po = 1'b0; ts = 1'b0; sel = 1'b0;

    // Reset state on both instances
    @(negedge clk);
    chk("rst_tx_a", tx_s, 1'b1);   chk("rst_busy_a", busy_s, 1'b0);
    chk("rst_ready_a", ready_s, 1'b0); chk("rst_done_a", fd_s, 1'b0);
    sel = 1'b1;
    #1;
    chk("rst_tx_b", tx_s, 1'b1);   chk("rst_busy_b", busy_s, 1'b0);
    chk("rst_ready_b", ready_s, 1'b0); chk("rst_done_b", fd_s, 1'b0);
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_chk();

    // Plain 8N1 frame of 0xA5
    present(1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0);
    frame(16'h00A5, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();

    // Even / odd parity, then two stop bits
    present(1'b0, 16'h00A5, 1'b1, 1'b0, 1'b0);
    frame(16'h00A5, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();
    present(1'b0, 16'h00A5, 1'b1, 1'b1, 1'b0);
    frame(16'h00A5, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();
    present(1'b0, 16'h00A5, 1'b0, 1'b0, 1'b1);
    frame(16'h00A5, 1'b0, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();

    // Back-to-back 0x3C then 0xFF with valid held high
    present(1'b0, 16'h003C, 1'b0, 1'b0, 1'b0);
    frame(16'h003C, 1'b0, 1'b0, 1'b0, 1, 16'h00FF, 1'b0, 1'b0, 1'b0);
    frame(16'h00FF, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();

    // New word offered mid-DATA with toggled options
    present(1'b0, 16'h005A, 1'b0, 1'b0, 1'b0);
    frame(16'h005A, 1'b0, 1'b0, 1'b0, 13, 16'h00C3, 1'b1, 1'b0, 1'b1);
    frame(16'h00C3, 1'b1, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();

    // Reset during data bit 3, then a zero frame
    rd = 16'($urandom) & 16'h00FF;
    present(1'b0, rd, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    dv_a = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst_bit3", tx_s, rd[3]);
    reset = 1'b1;
    #1;
    chk("abort_tx", tx_s, 1'b1);
    chk("abort_busy", busy_s, 1'b0);
    chk("abort_ready", ready_s, 1'b0);
    chk("abort_done", fd_s, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_chk();
    present(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    frame(16'h0000, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();

    // 5-bit / 2-clk instance: 0x15 with even parity
    present(1'b1, 16'h0015, 1'b1, 1'b0, 1'b0);
    frame(16'h0015, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    idle_chk();

    // Randomized frames on both instances
    rand_frames(1'b0, 8);
    rand_frames(1'b1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
